// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between IF and D.
// Optional IF starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              busy,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_DOUT,
    input  logic [31:0]       MEM_DI
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       ownerD;
    logic       forceIf;
    logic       dWin;
    logic       ifWin;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starveCnt;

    assign forceIf = if_req && (starveCnt >= 4'(STARVE_LIMIT));

    // Count D grants that locked out a pending fetch; any IF grant or idle IF clears
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            starveCnt <= 4'd0;
        end else if (state == IDLE) begin
            if (ifWin || !if_req)
                starveCnt <= 4'd0;
            else if (dWin && starveCnt != 4'hF)
                starveCnt <= starveCnt + 4'd1;
        end
    end
`else
    assign forceIf = 1'b0;
`endif

    assign dWin   = d_req && !forceIf;
    assign ifWin  = if_req && !dWin;
    assign d_gnt  = RSTn && (state == IDLE) && dWin;
    assign if_gnt = RSTn && (state == IDLE) && ifWin;
    assign busy   = (state != IDLE);

    // Transaction FSM with registered memory strobes and response pulses
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ownerD    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            MEM_ADDR  <= '0;
            MEM_BE    <= 4'd0;
            MEM_DOUT  <= 32'd0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dWin || ifWin) begin
                        ownerD  <= dWin;
                        MEM_CSN <= 1'b0;
                        cnt     <= 4'(LATENCY);
                        state   <= ACCESS;
                        if (dWin) begin
                            MEM_ADDR <= d_addr;
                            MEM_WEN  <= ~d_we;
                            MEM_BE   <= d_be;
                            MEM_DOUT <= d_wdata;
                        end else begin
                            MEM_ADDR <= if_addr;
                            MEM_WEN  <= 1'b1;
                            MEM_BE   <= 4'hF;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        MEM_CSN <= 1'b1;
                        MEM_WEN <= 1'b1;
                        state   <= RESP;
                        if (ownerD) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= MEM_WEN ? MEM_DI : 32'd0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= MEM_DI;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
